// File: rtl/usr_sequencer.sv
// usr_sequencer: FSM that turns hold/shift/load commands into control for an external universal shift register.
// Optional abort feature enabled by defining USR_SEQ_ABORT_EN (adds abort/aborted ports).

module usr_sequencer #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CW-1:0]    cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  output logic [1:0]       sr_ctrl,
  output logic [WIDTH-1:0] sr_d,
  input  logic [WIDTH-1:0] sr_q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
`ifdef USR_SEQ_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q, ready_d;
  logic [CW-1:0]    eff_count;
  logic             sr_q_unused;
`ifdef USR_SEQ_ABORT_EN
  logic             abrt_q, abrt_d;
`endif

  // Only the end bits of sr_q feed ser_out; the rest is intentionally ignored.
  assign sr_q_unused = ^sr_q;

  always_comb begin
    eff_count = cmd_count;
    if (int'(cmd_count) > WIDTH) eff_count = CW'(WIDTH);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    count_d   = count_q;
    ready_d   = 1'b1;
    cmd_ready = 1'b0;
    sr_ctrl   = 2'b00;
    sr_d      = '0;
    ser_out   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
`ifdef USR_SEQ_ABORT_EN
    abrt_d    = abrt_q;
    aborted   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // ready_q keeps cmd_ready low until the first edge after reset release.
        cmd_ready = ready_q;
        if (cmd_valid && ready_q) begin
`ifdef USR_SEQ_ABORT_EN
          abrt_d = 1'b0;
`endif
          case (cmd_op)
            2'b11: begin
              data_d  = cmd_data;
              state_d = LOAD;
            end
            2'b01, 2'b10: begin
              if (cmd_count != '0) begin
                op_d    = cmd_op;
                count_d = eff_count;
                state_d = SHIFT;
              end else begin
                state_d = DONE;
              end
            end
            default: state_d = DONE;
          endcase
        end
      end
      LOAD: begin
        busy    = 1'b1;
        sr_ctrl = 2'b11;
        sr_d    = data_q;
        state_d = DONE;
`ifdef USR_SEQ_ABORT_EN
        if (abort) abrt_d = 1'b1;
`endif
      end
      SHIFT: begin
        busy    = 1'b1;
        sr_ctrl = op_q;
        sr_d    = {WIDTH{ser_in}};
        ser_out = (op_q == 2'b01) ? sr_q[WIDTH-1] : sr_q[0];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = DONE;
`ifdef USR_SEQ_ABORT_EN
        if (abort) begin
          abrt_d  = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        count_d = '0;
        state_d = IDLE;
`ifdef USR_SEQ_ABORT_EN
        aborted = abrt_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      data_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
`ifdef USR_SEQ_ABORT_EN
      abrt_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      count_q <= count_d;
      ready_q <= ready_d;
`ifdef USR_SEQ_ABORT_EN
      abrt_q  <= abrt_d;
`endif
    end
  end

endmodule

// File: tb/tb_usr_sequencer.sv
// Directed bench for usr_sequencer with a behavioural universal shift register closing the sr_* loop.
// Abort scenario is compiled in when USR_SEQ_ABORT_EN is defined.

module tb_usr_sequencer;
  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [CW-1:0]    cmd_count = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             ser_in = 1'b0;
  logic             cmd_ready, ser_out, busy, done;
  logic [1:0]       sr_ctrl;
  logic [WIDTH-1:0] sr_d, sr_q;
`ifdef USR_SEQ_ABORT_EN
  logic             abort = 1'b0;
  logic             aborted;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Universal shift register: 00 hold, 01 left (LSB from sr_d[0]), 10 right (MSB from sr_d[MSB]), 11 load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sr_q <= '0;
    else begin
      case (sr_ctrl)
        2'b01:   sr_q <= {sr_q[WIDTH-2:0], sr_d[0]};
        2'b10:   sr_q <= {sr_d[WIDTH-1], sr_q[WIDTH-1:1]};
        2'b11:   sr_q <= sr_d;
        default: sr_q <= sr_q;
      endcase
    end
  end

  usr_sequencer #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data), .ser_in(ser_in),
    .sr_ctrl(sr_ctrl), .sr_d(sr_d), .sr_q(sr_q), .ser_out(ser_out),
    .busy(busy), .done(done)
`ifdef USR_SEQ_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  task automatic run_cmd(input logic [1:0] op, input logic [CW-1:0] cnt, input logic [WIDTH-1:0] data,
                         input logic sin, input int abort_at,
                         output int lat, output int n_shl, output int n_shr, output int n_ld,
                         output logic [WIDTH-1:0] ld_val, output logic [31:0] hist,
                         output int n_busy, output int n_rdy_busy, output logic ab_seen);
    int nsh;
    lat = -1; n_shl = 0; n_shr = 0; n_ld = 0; ld_val = '0; hist = '0;
    n_busy = 0; n_rdy_busy = 0; ab_seen = 1'b0; nsh = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_data = data; ser_in = sin;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (busy && cmd_ready) n_rdy_busy++;
      if (sr_ctrl == 2'b01 || sr_ctrl == 2'b10) begin
        if (sr_ctrl == 2'b01) n_shl++; else n_shr++;
        if (nsh < 32) hist[nsh] = ser_out;
        nsh++;
      end
      if (sr_ctrl == 2'b11) begin
        n_ld++;
        ld_val = sr_d;
      end
`ifdef USR_SEQ_ABORT_EN
      if (aborted) ab_seen = 1'b1;
      abort = (abort_at != 0) && (nsh == abort_at) && (sr_ctrl != 2'b00);
`endif
      if (done) begin
        lat = i;
        break;
      end
    end
`ifdef USR_SEQ_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done); end
    vectors++; if (sr_ctrl !== 2'b00) begin miscompares++; $display("FAIL reset_sr_ctrl got %b exp 00", sr_ctrl); end
    vectors++; if (sr_d !== 8'h00) begin miscompares++; $display("FAIL reset_sr_d got %h exp 00", sr_d); end
    vectors++; if (ser_out !== 1'b0) begin miscompares++; $display("FAIL reset_ser_out got %b exp 0", ser_out); end
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready got %b exp 1", cmd_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_release_busy got %b exp 0", busy); end
  endtask

  task automatic test_load();
    int lat, nl, nr, nld, nb, nrb; logic [WIDTH-1:0] lv; logic [31:0] h; logic ab;
    run_cmd(2'b11, 4'd0, 8'hA5, 1'b0, 0, lat, nl, nr, nld, lv, h, nb, nrb, ab);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL load_latency got %0d exp 2", lat); end
    vectors++; if (nld !== 1) begin miscompares++; $display("FAIL load_cycles got %0d exp 1", nld); end
    vectors++; if (lv !== 8'hA5) begin miscompares++; $display("FAIL load_sr_d got %h exp a5", lv); end
    vectors++; if (sr_q !== 8'hA5) begin miscompares++; $display("FAIL load_result got %h exp a5", sr_q); end
    vectors++; if (nb !== 2) begin miscompares++; $display("FAIL load_busy_cycles got %0d exp 2", nb); end
    vectors++; if (nrb !== 0) begin miscompares++; $display("FAIL load_ready_while_busy got %0d exp 0", nrb); end
    vectors++; if ((nl + nr) !== 0) begin miscompares++; $display("FAIL load_shift_cycles got %0d exp 0", nl + nr); end
  endtask

  task automatic test_shift_left();
    int lat, nl, nr, nld, nb, nrb; logic [WIDTH-1:0] lv; logic [31:0] h; logic ab;
    run_cmd(2'b11, 4'd0, 8'h81, 1'b0, 0, lat, nl, nr, nld, lv, h, nb, nrb, ab);
    run_cmd(2'b01, 4'd3, 8'h00, 1'b1, 0, lat, nl, nr, nld, lv, h, nb, nrb, ab);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL shl_latency got %0d exp 4", lat); end
    vectors++; if (nl !== 3) begin miscompares++; $display("FAIL shl_cycles got %0d exp 3", nl); end
    vectors++; if (h[2:0] !== 3'b001) begin miscompares++; $display("FAIL shl_ser_out got %b exp 001", h[2:0]); end
    vectors++; if (sr_q !== 8'h0F) begin miscompares++; $display("FAIL shl_result got %h exp 0f", sr_q); end
    vectors++; if (nb !== 4) begin miscompares++; $display("FAIL shl_busy_cycles got %0d exp 4", nb); end
`ifdef USR_SEQ_ABORT_EN
    vectors++; if (ab !== 1'b0) begin miscompares++; $display("FAIL shl_aborted got %b exp 0", ab); end
`endif
  endtask

  task automatic test_clamp();
    int lat, nl, nr, nld, nb, nrb; logic [WIDTH-1:0] lv; logic [31:0] h; logic ab;
    run_cmd(2'b11, 4'd0, 8'hF0, 1'b0, 0, lat, nl, nr, nld, lv, h, nb, nrb, ab);
    run_cmd(2'b10, 4'd12, 8'h00, 1'b0, 0, lat, nl, nr, nld, lv, h, nb, nrb, ab);
    vectors++; if (nr !== 8) begin miscompares++; $display("FAIL clamp_cycles got %0d exp 8", nr); end
    vectors++; if (lat !== 9) begin miscompares++; $display("FAIL clamp_latency got %0d exp 9", lat); end
    vectors++; if (h[7:0] !== 8'hF0) begin miscompares++; $display("FAIL clamp_ser_out got %h exp f0", h[7:0]); end
    vectors++; if (sr_q !== 8'h00) begin miscompares++; $display("FAIL clamp_result got %h exp 00", sr_q); end
  endtask

  task automatic test_count_zero();
    int lat, nl, nr, nld, nb, nrb; logic [WIDTH-1:0] lv; logic [31:0] h; logic ab;
    run_cmd(2'b11, 4'd0, 8'h3C, 1'b0, 0, lat, nl, nr, nld, lv, h, nb, nrb, ab);
    run_cmd(2'b01, 4'd0, 8'h00, 1'b1, 0, lat, nl, nr, nld, lv, h, nb, nrb, ab);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL zero_latency got %0d exp 1", lat); end
    vectors++; if (nl !== 0) begin miscompares++; $display("FAIL zero_shift_cycles got %0d exp 0", nl); end
    vectors++; if (sr_q !== 8'h3C) begin miscompares++; $display("FAIL zero_result got %h exp 3c", sr_q); end
    run_cmd(2'b00, 4'd5, 8'hFF, 1'b1, 0, lat, nl, nr, nld, lv, h, nb, nrb, ab);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL hold_latency got %0d exp 1", lat); end
    vectors++; if ((nl + nr + nld) !== 0) begin miscompares++; $display("FAIL hold_ctrl_cycles got %0d exp 0", nl + nr + nld); end
    vectors++; if (sr_q !== 8'h3C) begin miscompares++; $display("FAIL hold_result got %h exp 3c", sr_q); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] done_bits, rdy_bits, ld_bits;
    done_bits = '0; rdy_bits = '0; ld_bits = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 8'h5A; cmd_count = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      done_bits[i] = done;
      rdy_bits[i]  = cmd_ready;
      ld_bits[i]   = (sr_ctrl == 2'b11);
    end
    cmd_valid = 1'b0;
    vectors++; if (done_bits !== 6'b010010) begin miscompares++; $display("FAIL b2b_done got %b exp 010010", done_bits); end
    vectors++; if (rdy_bits !== 6'b100100) begin miscompares++; $display("FAIL b2b_ready got %b exp 100100", rdy_bits); end
    vectors++; if (ld_bits !== 6'b001001) begin miscompares++; $display("FAIL b2b_load got %b exp 001001", ld_bits); end
    vectors++; if (sr_q !== 8'h5A) begin miscompares++; $display("FAIL b2b_result got %h exp 5a", sr_q); end
  endtask

  task automatic test_reset_mid_shift();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 4'd5; ser_in = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    vectors++; if (sr_ctrl !== 2'b01) begin miscompares++; $display("FAIL rst_mid_pre_ctrl got %b exp 01", sr_ctrl); end
    reset = 1'b1;
    #1;
    vectors++; if (sr_ctrl !== 2'b00) begin miscompares++; $display("FAIL rst_mid_ctrl got %b exp 00", sr_ctrl); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ready got %b exp 0", cmd_ready); end
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    reset = 1'b0;
    @(negedge clk);
    if (done) done_seen++;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_release_ready got %b exp 1", cmd_ready); end
    @(negedge clk);
    if (done) done_seen++;
    vectors++; if (done_seen !== 0) begin miscompares++; $display("FAIL rst_mid_done_pulses got %0d exp 0", done_seen); end
  endtask

`ifdef USR_SEQ_ABORT_EN
  task automatic test_abort();
    int lat, nl, nr, nld, nb, nrb; logic [WIDTH-1:0] lv; logic [31:0] h; logic ab;
    run_cmd(2'b11, 4'd0, 8'h01, 1'b0, 0, lat, nl, nr, nld, lv, h, nb, nrb, ab);
    run_cmd(2'b01, 4'd6, 8'h00, 1'b0, 3, lat, nl, nr, nld, lv, h, nb, nrb, ab);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL abort_latency got %0d exp 4", lat); end
    vectors++; if (nl !== 3) begin miscompares++; $display("FAIL abort_shifts got %0d exp 3", nl); end
    vectors++; if (ab !== 1'b1) begin miscompares++; $display("FAIL abort_flag got %b exp 1", ab); end
    vectors++; if (sr_q !== 8'h08) begin miscompares++; $display("FAIL abort_result got %h exp 08", sr_q); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_shift_left();
    test_clamp();
    test_count_zero();
    test_back_to_back();
    test_reset_mid_shift();
`ifdef USR_SEQ_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usr_sequencer.md
USR_SEQUENCER -- requirements
Module: usr_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the width of the controlled universal shift register (minimum 2).
REQ-002 SHALL have parameter CW, default $clog2(WIDTH)+1, the width of the shift-count field.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): the command handshake.
REQ-006 SHALL have port cmd_op  input  2  command: 00 hold, 01 shift-left, 10 shift-right, 11 load.
REQ-007 SHALL have ports cmd_count (input, CW) and cmd_data (input, WIDTH): the shift count and the load data.
REQ-008 SHALL have port ser_in  input  1  serial bit shifted into the register.
REQ-009 SHALL have ports sr_ctrl (output, 2) and sr_d (output, WIDTH): the control and data inputs of the shift register.
REQ-010 SHALL have port sr_q  input  WIDTH  shift-register contents, fed back from the register.
REQ-011 SHALL have ports ser_out (output, 1), busy (output, 1) and done (output, 1): the bit shifted out, command-in-progress and completion pulse.

Function
REQ-012 SHALL implement the FSM states IDLE, LOAD, SHIFT and DONE; all outputs are Moore outputs decoded from the state, except ser_out.
REQ-013 In IDLE: cmd_ready=1, sr_ctrl=00, busy=0; a command is accepted only when cmd_valid and cmd_ready are both 1.
REQ-014 On accept, the FSM SHALL go to one of the following states:
- op 11: go to LOAD and latch cmd_data.
- op 01 or 10 with count>0: go to SHIFT and latch op and the effective count.
- op 00, or a shift with count=0: go to DONE.
REQ-015 The effective count SHALL equal min(cmd_count, WIDTH).
REQ-016 In LOAD (exactly 1 cycle): sr_ctrl=11 and sr_d=latched data; the next state is DONE.
REQ-017 In SHIFT (each cycle):
- sr_ctrl = the latched op.
- sr_d = {WIDTH{ser_in}}.
- The count decrements; when the count reaches 1, the next state is DONE.
REQ-018 While in SHIFT, ser_out SHALL be sr_q[WIDTH-1] for a left shift and sr_q[0] for a right shift; otherwise it is 0.
REQ-019 In DONE (exactly 1 cycle): sr_ctrl=00, done=1, and sr_q holds the final result; the next state is IDLE.
REQ-020 busy SHALL be 1 in LOAD, SHIFT and DONE, and cmd_ready SHALL be 0 in those states; cmd_valid in those states SHALL be ignored and not queued.
REQ-021 Latency from the accept edge to the done cycle SHALL be:
- load: 2 cycles.
- shift of N: N+1 cycles.
- hold or count 0: 1 cycle.
REQ-022 Back-to-back: a command SHALL be accepted at the earliest in the IDLE cycle that follows DONE.
REQ-023 When not in LOAD or SHIFT, sr_d SHALL be 0.

Reset
REQ-024 While reset=1, SHALL hold:
- state=IDLE and count=0.
- latched op/data = 0.
- sr_ctrl=00 and sr_d=0.
- done=0, busy=0, ser_out=0 and cmd_ready=0.
REQ-025 When reset is asserted mid-command, the command SHALL be dropped with no done pulse; after reset deasserts, the next clock cycle is IDLE with cmd_ready=1.

Configuration
REQ-026 With macro USR_SEQ_ABORT_EN defined, the block SHALL add the following ports:
- input abort (1).
- output aborted (1).
REQ-027 With USR_SEQ_ABORT_EN defined, abort=1 in LOAD or SHIFT SHALL force the next state to DONE with aborted=1 alongside done; the remaining shifts are skipped, and a LOAD cycle during which abort is sampled still drives sr_ctrl=11.
REQ-028 Without USR_SEQ_ABORT_EN, the abort and aborted ports SHALL be absent and every accepted command SHALL run to completion.

Verification
REQ-029 Load: load 0xA5 -> one cycle of sr_ctrl=11 with sr_d=0xA5; done 2 cycles after accept; sr_q=0xA5.
REQ-030 Shift-left: after loading 0x81, shift-left count 3 with ser_in=1 -> three cycles of sr_ctrl=01; ser_out 1,0,0; at done sr_q=0x0F.
REQ-031 Clamp: after loading 0xF0, shift-right count 12 with ser_in=0 -> exactly 8 shift cycles; sr_q=0x00 at done.
REQ-032 Count zero: shift-left count 0 -> no sr_ctrl=01 cycle; done 1 cycle after accept; sr_q unchanged.
REQ-033 Reset mid-shift: reset asserted after 2 of 5 shifts -> sr_ctrl=00 immediately; no done pulse; cmd_ready=1 one cycle after release.
REQ-034 Abort (USR_SEQ_ABORT_EN): abort during the 3rd of 6 shifts -> done=1 and aborted=1 on the next cycle; exactly 3 shifts applied.
